// File: rtl/jelly2_ram_arbiter_pkg.sv
// Shared types and helpers for the auto-clear RAM arbiter and its round-robin grant logic.
package jelly2_ram_arbiter_pkg;

    localparam int RR_MAX_NUM   = 16;
    localparam int RR_PTR_WIDTH = 4;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        START,
        WAIT_HI,
        WAIT_LO
    } arb_state_t;

    // Scan upward from ptr with wrap at num; the first valid bit wins.
    function automatic logic [RR_MAX_NUM-1:0] rr_grant(
        input logic [RR_MAX_NUM-1:0]   valid,
        input logic [RR_PTR_WIDTH-1:0] ptr,
        input int                      num
    );
        logic [RR_MAX_NUM-1:0] grant;
        logic                  found;
        logic [4:0]            idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_NUM; i++) begin
            if (i < num) begin
                idx = 5'(ptr) + 5'(i);
                if (idx >= 5'(num)) begin
                    idx = idx - 5'(num);
                end
                if (!found && valid[idx[3:0]]) begin
                    grant[idx[3:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/jelly2_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on each grant.
module jelly2_rr_arbiter
    import jelly2_ram_arbiter_pkg::*;
#(
    parameter int NUM      = 4,
    parameter int ID_WIDTH = (NUM > 1) ? $clog2(NUM) : 1
)
(
    input  logic                reset,
    input  logic                clk,
    input  logic                enable,
    input  logic [NUM-1:0]      valid,
    output logic [NUM-1:0]      grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic [ID_WIDTH-1:0]   ptr;
    logic [RR_MAX_NUM-1:0] full_grant;

    assign full_grant = rr_grant(RR_MAX_NUM'(valid), RR_PTR_WIDTH'(ptr), NUM);
    assign grant      = enable ? full_grant[NUM-1:0] : '0;

    generate
        if (NUM < RR_MAX_NUM) begin : g_tail
            logic unused_bits;
            assign unused_bits = &{1'b0, full_grant[RR_MAX_NUM-1:NUM]};
        end
    endgenerate

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM; i++) begin
            if (grant[i]) begin
                grant_id = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end
        else if (|grant) begin
            ptr <= (grant_id == ID_WIDTH'(NUM - 1)) ? '0 : grant_id + ID_WIDTH'(1);
        end
    end

endmodule

// File: rtl/jelly2_ram_autoclear_arbiter.sv
// Shares one auto-clear RAM port among NUM requesters and sequences clears so that
// no read is lost and no access overlaps the RAM's own clear sweep.
module jelly2_ram_autoclear_arbiter
    import jelly2_ram_arbiter_pkg::*;
#(
    parameter int NUM          = 4,
    parameter int ID_WIDTH     = (NUM > 1) ? $clog2(NUM) : 1,
    parameter int ADDR_WIDTH   = 12,
    parameter int WE_WIDTH     = 1,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
)
(
    input  logic                           reset,
    input  logic                           clk,

    input  logic                           s_clear_req,
    input  logic [DATA_WIDTH-1:0]          s_clear_din,
    output logic                           s_clear_ack,
    output logic                           clear_busy,

    input  logic [NUM-1:0]                 s_valid,
    output logic [NUM-1:0]                 s_ready,
    input  logic [NUM*WE_WIDTH-1:0]        s_we,
    input  logic [NUM*ADDR_WIDTH-1:0]      s_addr,
    input  logic [NUM*DATA_WIDTH-1:0]      s_din,
    output logic [NUM-1:0]                 m_rvalid,
    output logic [DATA_WIDTH-1:0]          m_rdata,

    output logic [DATA_WIDTH-1:0]          ram_clear_din,
    output logic                           ram_clear_start,
    input  logic                           ram_clear_busy,
    output logic                           ram_en,
    output logic                           ram_regcke,
    output logic [WE_WIDTH-1:0]            ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_din,
    input  logic [DATA_WIDTH-1:0]          ram_dout
);

    arb_state_t          state;
    logic                arb_enable;
    logic [NUM-1:0]      grant;
    logic [ID_WIDTH-1:0] grant_id;
    logic                handshake;
    logic [WE_WIDTH-1:0] sel_we;
    logic                is_read;
    logic [NUM-1:0]      tag_pipe [0:READ_LATENCY];
    logic                tag_any;

    // A pending clear request wins over requesters in the same cycle.
    assign arb_enable = (state == RUN) && !s_clear_req;

    jelly2_rr_arbiter #(
        .NUM      (NUM),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .reset    (reset),
        .clk      (clk),
        .enable   (arb_enable),
        .valid    (s_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign s_ready    = grant;
    assign handshake  = |grant;
    assign sel_we     = s_we[int'(grant_id)*WE_WIDTH +: WE_WIDTH];
    assign is_read    = (sel_we == '0);
    assign clear_busy = (state != RUN);
    assign ram_regcke = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_en   <= 1'b0;
            ram_we   <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
        end
        else begin
            ram_en <= handshake;
            ram_we <= handshake ? sel_we : '0;
            if (handshake) begin
                ram_addr <= s_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                ram_din  <= s_din[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The one-hot tag rides alongside the RAM pipeline so read data returns to its owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            m_rvalid <= '0;
            m_rdata  <= '0;
        end
        else begin
            tag_pipe[0] <= (handshake && is_read) ? grant : '0;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            m_rvalid <= tag_pipe[READ_LATENCY];
            if (|tag_pipe[READ_LATENCY]) begin
                m_rdata <= ram_dout;
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            tag_any = tag_any | (|tag_pipe[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            s_clear_ack     <= 1'b0;
            ram_clear_start <= 1'b0;
            ram_clear_din   <= '0;
        end
        else begin
            s_clear_ack     <= 1'b0;
            ram_clear_start <= 1'b0;
            case (state)
                RUN: begin
                    if (s_clear_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Start only once every outstanding read has reached m_rvalid.
                    if (!ram_en && !tag_any) begin
                        state           <= START;
                        s_clear_ack     <= 1'b1;
                        ram_clear_start <= 1'b1;
                        ram_clear_din   <= s_clear_din;
                    end
                end
                START: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (ram_clear_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!ram_clear_busy) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jelly2_ram_autoclear_arbiter.sv
// Directed bench: two arbiter instances (READ_LATENCY 1 and 2), each with a behavioural auto-clear RAM.
module tb_jelly2_ram_autoclear_arbiter;

    localparam int NUM = 4;
    localparam int AW  = 12;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset         [2];
    logic          sClearReq     [2];
    logic [DW-1:0] sClearDin     [2];
    logic          sClearAck     [2];
    logic          clearBusy     [2];
    logic [3:0]    sValid        [2];
    logic [3:0]    sReady        [2];
    logic [3:0]    sWe           [2];
    logic [47:0]   sAddr         [2];
    logic [31:0]   sDin          [2];
    logic [3:0]    mRvalid       [2];
    logic [DW-1:0] mRdata        [2];
    logic [DW-1:0] ramClearDin   [2];
    logic          ramClearStart [2];
    logic          ramClearBusy  [2];
    logic          ramEn         [2];
    logic          ramRegcke     [2];
    logic [0:0]    ramWe         [2];
    logic [AW-1:0] ramAddr       [2];
    logic [DW-1:0] ramDin        [2];
    logic [DW-1:0] ramDout       [2];

    int         checkCount = 0;
    int         errorCount = 0;
    int         cyc        = 0;
    int         pending    [2];
    logic [3:0] expRv      [2][64];
    logic [7:0] expRd      [2][64];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_inst
            logic [7:0] mem [0:4095];
            logic [7:0] d0;
            logic [7:0] d1;
            logic       busy;
            int         clrCnt;

            jelly2_ram_autoclear_arbiter #(
                .NUM          (NUM),
                .ADDR_WIDTH   (AW),
                .WE_WIDTH     (1),
                .DATA_WIDTH   (DW),
                .READ_LATENCY (g + 1)
            ) u_dut (
                .reset           (reset[g]),
                .clk             (clk),
                .s_clear_req     (sClearReq[g]),
                .s_clear_din     (sClearDin[g]),
                .s_clear_ack     (sClearAck[g]),
                .clear_busy      (clearBusy[g]),
                .s_valid         (sValid[g]),
                .s_ready         (sReady[g]),
                .s_we            (sWe[g]),
                .s_addr          (sAddr[g]),
                .s_din           (sDin[g]),
                .m_rvalid        (mRvalid[g]),
                .m_rdata         (mRdata[g]),
                .ram_clear_din   (ramClearDin[g]),
                .ram_clear_start (ramClearStart[g]),
                .ram_clear_busy  (ramClearBusy[g]),
                .ram_en          (ramEn[g]),
                .ram_regcke      (ramRegcke[g]),
                .ram_we          (ramWe[g]),
                .ram_addr        (ramAddr[g]),
                .ram_din         (ramDin[g]),
                .ram_dout        (ramDout[g])
            );

            initial begin
                for (int i = 0; i < 4096; i++) begin
                    mem[i] = (i < 4) ? 8'(8'h10 + i) : 8'h00;
                end
            end

            // Read-first RAM; a clear keeps busy high for six cycles and then fills the array.
            always @(posedge clk) begin
                if (reset[g]) begin
                    d0     <= 8'h00;
                    d1     <= 8'h00;
                    busy   <= 1'b0;
                    clrCnt <= 0;
                end
                else begin
                    if (ramEn[g]) begin
                        if (ramWe[g][0]) begin
                            mem[ramAddr[g]] <= ramDin[g];
                        end
                        d0 <= mem[ramAddr[g]];
                    end
                    d1 <= d0;
                    if (ramClearStart[g]) begin
                        busy   <= 1'b1;
                        clrCnt <= 6;
                    end
                    else if (clrCnt > 1) begin
                        clrCnt <= clrCnt - 1;
                    end
                    else if (clrCnt == 1) begin
                        clrCnt <= 0;
                        busy   <= 1'b0;
                        for (int i = 0; i < 4096; i++) begin
                            mem[i] <= ramClearDin[g];
                        end
                    end
                end
            end

            assign ramClearBusy[g] = busy;
            assign ramDout[g]      = (g == 0) ? d0 : d1;
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Compares the read-return port against the expectation scheduled for this cycle.
    task automatic monitor(input int k);
        int slot;
        slot = cyc % 64;
        if (expRv[k][slot] != 4'b0 || mRvalid[k] != 4'b0) begin
            checkOutput("m_rvalid", 32'(mRvalid[k]), 32'(expRv[k][slot]));
            if (expRv[k][slot] != 4'b0) begin
                checkOutput("m_rdata", 32'(mRdata[k]), 32'(expRd[k][slot]));
                pending[k]--;
            end
        end
        expRv[k][slot] = 4'b0;
    endtask

    task automatic pushRead(input int k, input logic [3:0] oneHot, input logic [7:0] data);
        for (int r = 0; r < NUM; r++) begin
            if (oneHot[r] && !sWe[k][r]) begin
                expRv[k][(cyc + 3 + k) % 64] = oneHot;
                expRd[k][(cyc + 3 + k) % 64] = data;
                pending[k]++;
            end
        end
    endtask

    task automatic setReq(input int k, input int r, input logic we, input logic [11:0] addr, input logic [7:0] din);
        sWe[k][r]           = we;
        sAddr[k][r*AW +: AW] = addr;
        sDin[k][r*DW +: DW]  = din;
    endtask

    task automatic applyStimulus(input int k, input logic [3:0] valid, input logic clr,
                                 input logic [3:0] expReady, input logic [7:0] expData);
        sValid[k]    = valid;
        sClearReq[k] = clr;
        @(negedge clk);
        monitor(k);
        checkOutput("s_ready", 32'(sReady[k]), 32'(expReady));
        if (expReady != 4'b0) begin
            pushRead(k, expReady, expData);
        end
        nextEdge();
    endtask

    task automatic resetDut(input int k);
        reset[k]     = 1'b1;
        sValid[k]    = 4'b0;
        sClearReq[k] = 1'b0;
        pending[k]   = 0;
        for (int i = 0; i < 64; i++) begin
            expRv[k][i] = 4'b0;
        end
        nextEdge();
        @(negedge clk);
        checkOutput("rst_clear_busy", 32'(clearBusy[k]), 32'd0);
        checkOutput("rst_m_rvalid", 32'(mRvalid[k]), 32'd0);
        checkOutput("rst_s_ready", 32'(sReady[k]), 32'd0);
        checkOutput("rst_ram_en", 32'(ramEn[k]), 32'd0);
        checkOutput("rst_ack", 32'(sClearAck[k]), 32'd0);
        checkOutput("rst_clear_start", 32'(ramClearStart[k]), 32'd0);
        nextEdge();
        reset[k] = 1'b0;
    endtask

    task automatic waitAck(input int k, input logic [7:0] din);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            monitor(k);
            checkOutput("busy_in_clear", 32'(clearBusy[k]), 32'd1);
            checkOutput("ready_blocked", 32'(sReady[k]), 32'd0);
            if (sClearAck[k]) begin
                checkOutput("pending_at_ack", 32'(pending[k]), 32'd0);
                checkOutput("clear_start", 32'(ramClearStart[k]), 32'd1);
                checkOutput("clear_din", 32'(ramClearDin[k]), 32'(din));
                nextEdge();
                sClearReq[k] = 1'b0;
                @(negedge clk);
                monitor(k);
                checkOutput("ack_pulse", 32'(sClearAck[k]), 32'd0);
                nextEdge();
                break;
            end
            n++;
            if (n > 60) begin
                checkOutput("ack_timeout", 32'd0, 32'd1);
                break;
            end
            nextEdge();
        end
    endtask

    task automatic waitClearDone(input int k, input logic [3:0] valid, input logic [3:0] expFirst,
                                 input logic [7:0] expData);
        int   n;
        int   fallCyc;
        logic prevBusy;
        logic seenHi;
        n        = 0;
        fallCyc  = -100;
        prevBusy = 1'b0;
        seenHi   = 1'b0;
        sValid[k] = valid;
        forever begin
            @(negedge clk);
            monitor(k);
            if (ramClearBusy[k]) begin
                seenHi = 1'b1;
                checkOutput("busy_with_ram", 32'(clearBusy[k]), 32'd1);
            end
            else if (prevBusy) begin
                fallCyc = cyc;
            end
            prevBusy = ramClearBusy[k];
            if (!clearBusy[k]) begin
                checkOutput("ram_busy_seen", 32'(seenHi), 32'd1);
                checkOutput("busy_fall_lag", 32'(cyc - fallCyc), 32'd1);
                checkOutput("first_grant", 32'(sReady[k]), 32'(expFirst));
                if (expFirst != 4'b0) begin
                    pushRead(k, expFirst, expData);
                end
                nextEdge();
                break;
            end
            checkOutput("ready_blocked", 32'(sReady[k]), 32'd0);
            n++;
            if (n > 60) begin
                checkOutput("clear_timeout", 32'd0, 32'd1);
                break;
            end
            nextEdge();
        end
    endtask

    task automatic idle(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(k, 4'b0000, 1'b0, 4'b0000, 8'h00);
        end
    endtask

    task automatic runTests(input int k);
        resetDut(k);

        // Round-robin over four readers: grants 0,1,2,3,0.
        for (int r = 0; r < NUM; r++) begin
            setReq(k, r, 1'b0, 12'(r), 8'h00);
        end
        applyStimulus(k, 4'b1111, 1'b0, 4'b0001, 8'h10);
        applyStimulus(k, 4'b1111, 1'b0, 4'b0010, 8'h11);
        applyStimulus(k, 4'b1111, 1'b0, 4'b0100, 8'h12);
        applyStimulus(k, 4'b1111, 1'b0, 4'b1000, 8'h13);
        applyStimulus(k, 4'b1111, 1'b0, 4'b0001, 8'h10);
        idle(k, 6);

        // Write then read back; pointer is 1 here.
        setReq(k, 2, 1'b1, 12'h005, 8'hA5);
        applyStimulus(k, 4'b0100, 1'b0, 4'b0100, 8'h00);
        setReq(k, 0, 1'b0, 12'h005, 8'h00);
        applyStimulus(k, 4'b0001, 1'b0, 4'b0001, 8'hA5);
        idle(k, 6);

        // Reads in flight, then a clear to 0x00.
        setReq(k, 1, 1'b0, 12'h001, 8'h00);
        setReq(k, 3, 1'b0, 12'h003, 8'h00);
        sClearDin[k] = 8'h00;
        applyStimulus(k, 4'b1010, 1'b0, 4'b0010, 8'h11);
        applyStimulus(k, 4'b1010, 1'b0, 4'b1000, 8'h13);
        applyStimulus(k, 4'b1010, 1'b1, 4'b0000, 8'h00);
        waitAck(k, 8'h00);
        waitClearDone(k, 4'b0000, 4'b0000, 8'h00);

        // Cleared location reads back zero; pointer is 0.
        applyStimulus(k, 4'b0001, 1'b0, 4'b0001, 8'h00);
        idle(k, 6);

        // Clear and all requesters in the same cycle; resume at pointer 1.
        for (int r = 0; r < NUM; r++) begin
            setReq(k, r, 1'b0, 12'(r), 8'h00);
        end
        sClearDin[k] = 8'h5A;
        applyStimulus(k, 4'b1111, 1'b1, 4'b0000, 8'h00);
        waitAck(k, 8'h5A);
        waitClearDone(k, 4'b1111, 4'b0010, 8'h5A);
        applyStimulus(k, 4'b1111, 1'b0, 4'b0100, 8'h5A);
        applyStimulus(k, 4'b1111, 1'b0, 4'b1000, 8'h5A);
        applyStimulus(k, 4'b1111, 1'b0, 4'b0001, 8'h5A);
        idle(k, 6);

        // Reset while waiting for the RAM clear to finish.
        sClearDin[k] = 8'h77;
        applyStimulus(k, 4'b0000, 1'b1, 4'b0000, 8'h00);
        waitAck(k, 8'h77);
        @(negedge clk);
        monitor(k);
        checkOutput("wait_lo_busy", 32'(clearBusy[k]), 32'd1);
        checkOutput("wait_lo_ram_busy", 32'(ramClearBusy[k]), 32'd1);
        nextEdge();
        resetDut(k);
        for (int r = 0; r < NUM; r++) begin
            setReq(k, r, 1'b1, 12'h040, 8'h00);
        end
        applyStimulus(k, 4'b1111, 1'b0, 4'b0001, 8'h00);
        idle(k, 6);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k]     = 1'b1;
            sClearReq[k] = 1'b0;
            sClearDin[k] = 8'h00;
            sValid[k]    = 4'b0;
            sWe[k]       = 4'b0;
            sAddr[k]     = 48'h0;
            sDin[k]      = 32'h0;
            pending[k]   = 0;
            for (int i = 0; i < 64; i++) begin
                expRv[k][i] = 4'b0;
                expRd[k][i] = 8'h00;
            end
        end
        nextEdge();
        runTests(0);
        runTests(1);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
